// File: rtl/ev22_fetch_seq.sv
// EV22 instruction fetch/sequencer: fetches 18-bit words, issues them to the
// decoder, waits for execution, then resolves the next PC (branches, BSR/RET).
module ev22_fetch_seq #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic            imem_valid,
  input  logic [17:0]     imem_data,
  output logic [7:0]      OPCODE,
  output logic [4:0]      Ri,
  output logic [4:0]      Rj,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            z_flag,
  input  logic            w15,
  input  logic            cy_flag,
  output logic [PC_W-1:0] pc,
  output logic            stack_err
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [4:0]      ri_q, ri_d, rj_q, rj_d;
  logic            imem_rd_q, imem_rd_d;
  logic            instr_valid_q, instr_valid_d;
  logic            stack_err_q, stack_err_d;
  logic            done_q, done_d;
  logic            z_q, z_d, w15_q, w15_d, cy_q, cy_d;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];

  logic [PC_W-1:0] next_pc, target, offset, pc_inc, ret_addr;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic            is_bsr, is_ret, stack_full, stack_empty, stack_we;

  // Next-PC resolution from the held opcode and the flags sampled at exec_done
  always_comb begin
    target      = PC_W'({ri_q, rj_q});
    offset      = PC_W'($signed({ri_q, rj_q}));
    pc_inc      = pc_q + PC_W'(1);
    push_idx    = IDX_W'(sp_q);
    pop_idx     = IDX_W'(sp_q - SP_W'(1));
    ret_addr    = stack_q[pop_idx];
    stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    stack_empty = (sp_q == SP_W'(0));
    is_bsr      = 1'b0;
    is_ret      = 1'b0;
    next_pc     = pc_inc;
    casez (opcode_q)
      8'b00100???: next_pc = target;
      8'b00101???: next_pc = z_q ? target : pc_inc;
      8'b00110???: next_pc = !w15_q ? target : pc_inc;
      8'b00111???: next_pc = cy_q ? target : pc_inc;
      8'b000111??: begin
        is_bsr  = 1'b1;
        next_pc = pc_q + offset;
      end
      8'b01000001: begin
        is_ret  = 1'b1;
        next_pc = stack_empty ? pc_inc : ret_addr + PC_W'(1);
      end
      default: next_pc = pc_inc;
    endcase
  end

  // Sequencer next-state and register updates
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    opcode_d    = opcode_q;
    ri_d        = ri_q;
    rj_d        = rj_q;
    stack_err_d = stack_err_q;
    done_d      = done_q;
    z_d         = z_q;
    w15_d       = w15_q;
    cy_d        = cy_q;
    stack_we    = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid) begin
          opcode_d = imem_data[17:10];
          ri_d     = imem_data[9:5];
          rj_d     = imem_data[4:0];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_EXEC;
        if (exec_done) begin
          done_d = 1'b1;
          z_d    = z_flag;
          w15_d  = w15;
          cy_d   = cy_flag;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          z_d     = z_flag;
          w15_d   = w15;
          cy_d    = cy_flag;
          done_d  = 1'b0;
          state_d = S_NEXT;
        end else if (done_q) begin
          done_d  = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        pc_d = next_pc;
        if (is_bsr) begin
          if (stack_full) stack_err_d = 1'b1;
          else begin
            stack_we = 1'b1;
            sp_d     = sp_q + SP_W'(1);
          end
        end
        if (is_ret) begin
          if (stack_empty) stack_err_d = 1'b1;
          else sp_d = sp_q - SP_W'(1);
        end
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    imem_rd_d     = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      sp_q          <= '0;
      opcode_q      <= '0;
      ri_q          <= '0;
      rj_q          <= '0;
      imem_rd_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      stack_err_q   <= 1'b0;
      done_q        <= 1'b0;
      z_q           <= 1'b0;
      w15_q         <= 1'b0;
      cy_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      opcode_q      <= opcode_d;
      ri_q          <= ri_d;
      rj_q          <= rj_d;
      imem_rd_q     <= imem_rd_d;
      instr_valid_q <= instr_valid_d;
      stack_err_q   <= stack_err_d;
      done_q        <= done_d;
      z_q           <= z_d;
      w15_q         <= w15_d;
      cy_q          <= cy_d;
    end
  end

  // Return-address storage; contents are only meaningful below sp
  always_ff @(posedge clk) begin
    if (stack_we) stack_q[push_idx] <= pc_q;
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = imem_rd_q;
  assign OPCODE      = opcode_q;
  assign Ri          = ri_q;
  assign Rj          = rj_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_ev22_fetch_seq.sv
// Bench for ev22_fetch_seq: memory/datapath responders plus a scoreboard of
// expected fetch addresses and issued words.
module tb_ev22_fetch_seq;
  localparam int unsigned PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic            imem_valid;
  logic [17:0]     imem_data;
  logic [7:0]      OPCODE;
  logic [4:0]      Ri, Rj;
  logic            instr_valid;
  logic            exec_done = 1'b0;
  logic            z_flag = 1'b0, w15 = 1'b0, cy_flag = 1'b0;
  logic [PC_W-1:0] pc;
  logic            stack_err;

  logic            mem_valid = 1'b0, late_valid = 1'b0, hold_mem = 1'b0;
  logic [17:0]     mem_data = '0;
  assign imem_valid = mem_valid | late_valid;
  assign imem_data  = late_valid ? 18'h3FFFF : mem_data;

  ev22_fetch_seq #(.PC_W(PC_W), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_valid(imem_valid), .imem_data(imem_data), .OPCODE(OPCODE), .Ri(Ri), .Rj(Rj),
    .instr_valid(instr_valid), .exec_done(exec_done), .z_flag(z_flag), .w15(w15),
    .cy_flag(cy_flag), .pc(pc), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  logic [17:0] imem [1024];
  logic        fz [1024];
  logic        fw [1024];
  logic        fc [1024];

  typedef struct {
    logic [9:0] addr;
    logic       serr;
  } exp_t;
  logic [9:0] addr_q [$];
  exp_t       iss_q [$];

  int checks = 0, passes = 0;
  int cyc = 0, last_iv = -1;
  logic [9:0] cur_addr = '0, mem_a = '0;
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction memory: answers one cycle after the read strobe
  always begin
    @(negedge clk);
    if (imem_rd && !hold_mem) begin
      mem_a = imem_addr;
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_data  = imem[mem_a];
      cur_addr  = mem_a;
      @(posedge clk); #1;
      mem_valid = 1'b0;
    end
  end

  // Datapath: completes one cycle after issue with per-address flags
  always begin
    @(negedge clk);
    if (instr_valid) begin
      @(posedge clk); #1;
      exec_done = 1'b1;
      z_flag    = fz[cur_addr];
      w15       = fw[cur_addr];
      cy_flag   = fc[cur_addr];
      @(posedge clk); #1;
      exec_done = 1'b0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (imem_rd && addr_q.size() > 0)
        check("fetch_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
      if (instr_valid && iss_q.size() > 0) begin
        e = iss_q.pop_front();
        check("issued_word", 32'({OPCODE, Ri, Rj}), 32'(imem[e.addr]));
        check("stack_err_at_issue", 32'(stack_err), 32'(e.serr));
        if (last_iv >= 0) check("issue_spacing", 32'(cyc - last_iv), 32'd5);
        last_iv = cyc;
      end
    end
  end

  logic [9:0] seq [22] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h155, 10'h156,
                           10'h020, 10'h040, 10'h041, 10'h010, 10'h00E, 10'h011,
                           10'h017, 10'h01D, 10'h023, 10'h029, 10'h02F, 10'h024,
                           10'h01E, 10'h018, 10'h012, 10'h013};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i] = '0; fz[i] = 1'b0; fw[i] = 1'b0; fc[i] = 1'b0;
    end
    imem[10'h003] = {8'h20, 10'h155};
    imem[10'h155] = {8'h2D, 10'h020};
    imem[10'h156] = {8'h28, 10'h020};
    imem[10'h020] = {8'h38, 10'h040};
    imem[10'h040] = {8'h30, 10'h080};
    imem[10'h041] = {8'h20, 10'h010};
    imem[10'h010] = {8'h1C, 10'h3FE};
    imem[10'h00E] = {8'h41, 10'h000};
    imem[10'h011] = {8'h1C, 10'h006};
    imem[10'h017] = {8'h1F, 10'h006};
    imem[10'h01D] = {8'h1C, 10'h006};
    imem[10'h023] = {8'h1D, 10'h006};
    imem[10'h029] = {8'h1C, 10'h006};
    imem[10'h02F] = {8'h41, 10'h000};
    imem[10'h024] = {8'h41, 10'h000};
    imem[10'h01E] = {8'h41, 10'h000};
    imem[10'h018] = {8'h41, 10'h000};
    imem[10'h012] = {8'h41, 10'h000};
    imem[10'h013] = {8'h20, 10'h013};
    fz[10'h156] = 1'b1;
    fc[10'h020] = 1'b1;
    fw[10'h040] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_imem_rd", 32'(imem_rd), 32'd0);
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_opcode", 32'(OPCODE), 32'd0);
    check("reset_stack_err", 32'(stack_err), 32'd0);

    for (int i = 0; i < 22; i++) begin
      addr_q.push_back(seq[i]);
      iss_q.push_back('{addr: seq[i], serr: (i >= 16)});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run = 1'b1;

    for (int i = 0; i < 2000 && iss_q.size() > 0; i++) @(posedge clk);
    if (iss_q.size() > 0) begin
      checks++;
      $display("FAIL program_timeout: %0d issues outstanding, expected 0", iss_q.size());
    end
    #1;
    run = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_pc", 32'(pc), 32'h013);
    check("stack_err_sticky", 32'(stack_err), 32'd1);
    check("idle_no_fetch", 32'(imem_rd), 32'd0);

    // Reset while a fetch is outstanding
    hold_mem = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (imem_rd) break;
    end
    check("rst_test_fetch", 32'(imem_rd), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_opcode", 32'({OPCODE, Ri, Rj}), 32'd0);
    check("async_rst_imem_rd", 32'(imem_rd), 32'd0);
    check("async_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("async_rst_stack_err", 32'(stack_err), 32'd0);
    late_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    late_valid = 1'b0;
    check("late_valid_opcode", 32'({OPCODE, Ri, Rj}), 32'd0);
    check("late_valid_pc", 32'(pc), 32'd0);
    check("late_valid_instr_valid", 32'(instr_valid), 32'd0);
    check("late_valid_imem_rd", 32'(imem_rd), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
